gs_px_router: RTL and testbench

- Parametrised pixel-stream router between the grayscale/Sobel core and the pixel sources and sink.
- Sources are SPI plus one or more LFSR generators.
- Selects one of NUM_SRC source lanes per frame and forwards its pixels to the core.
- Counts pixels in and out against a frame length, and buffers core results in a FIFO so the slow SPI sink can drain at its own rate.
- Replaces the fixed two-way ternary muxing with a frame-aware, buffered, N-source router.

---
 rtl/gs_router_pkg.sv | 20 ++
 rtl/gs_px_fifo.sv | 61 ++++++
 rtl/gs_px_router.sv | 167 ++++++++++++++++
 tb/tb_gs_px_router.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gs_router_pkg.sv
// Shared types, default sizes and width helper for the gs_px_router pixel router.
package gs_router_pkg;

    localparam int DEF_PX_W       = 8;
    localparam int DEF_NUM_SRC    = 2;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_FRAME_LEN  = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // $clog2 that never yields a zero-width vector.
    function automatic int clog2_safe(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/gs_px_fifo.sv
// Result FIFO: combinational head, no fall-through, push and pop both honoured when full.
module gs_px_fifo
    import gs_router_pkg::*;
#(
    parameter int PX_W       = DEF_PX_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic [PX_W-1:0] push_px_i,
    input  logic            pop_i,
    output logic [PX_W-1:0] head_px_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int AW = clog2_safe(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [PX_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            do_push, do_pop;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign head_px_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_pop   = pop_i && !empty_o;
        // A pop frees the slot the push needs, so a full FIFO still accepts.
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; validity is tracked by the pointers and the head is masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_px_i;
        end
    end

endmodule

// File: rtl/gs_px_router.sv
// Frame-aware N-source pixel router with buffered core results.
// Optional macro GS_ROUTER_BYPASS_EN adds bypass_i to route source pixels straight into the FIFO.
module gs_px_router
    import gs_router_pkg::*;
#(
    parameter int PX_W       = DEF_PX_W,
    parameter int NUM_SRC    = DEF_NUM_SRC,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int FRAME_LEN  = DEF_FRAME_LEN
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  start_i,
    input  logic                                  abort_i,
    input  logic [clog2_safe(NUM_SRC)-1:0]        src_sel_i,
`ifdef GS_ROUTER_BYPASS_EN
    input  logic                                  bypass_i,
`endif
    input  logic [NUM_SRC*PX_W-1:0]               src_px_i,
    input  logic [NUM_SRC-1:0]                    src_rdy_i,
    output logic [PX_W-1:0]                       core_px_o,
    output logic                                  core_rdy_o,
    input  logic [PX_W-1:0]                       core_px_i,
    input  logic                                  core_rdy_i,
    output logic [PX_W-1:0]                       out_px_o,
    output logic                                  out_valid_o,
    input  logic                                  out_pop_i,
    output logic                                  busy_o,
    output logic                                  frame_done_o,
    output logic                                  overflow_o,
    output logic [clog2_safe(FRAME_LEN+1)-1:0]    in_cnt_o
);

    localparam int SW = clog2_safe(NUM_SRC);
    localparam int CW = clog2_safe(FRAME_LEN + 1);
    localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_LEN);

    state_e          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [CW-1:0]   in_cnt_q, in_cnt_d;
    logic [CW-1:0]   res_cnt_q, res_cnt_d;
    logic [PX_W-1:0] core_px_q, core_px_d;
    logic            core_rdy_q, core_rdy_d;
    logic            overflow_q, overflow_d;

    logic            start_acc, abort_acc, accept, last_px, res_done;
    logic            lane_rdy, bypass_active, push, fifo_full, fifo_empty;
    logic [PX_W-1:0] lane_px, push_px;

    assign start_acc = (state_q == ST_IDLE) && start_i && !abort_i;
    assign abort_acc = (state_q != ST_IDLE) && abort_i;
    assign accept    = (state_q == ST_RUN) && !abort_i && lane_rdy;
    assign last_px   = accept && (in_cnt_q == FRAME_CNT - 1'b1);
    assign res_done  = (res_cnt_q == FRAME_CNT);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        lane_px  = '0;
        lane_rdy = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel_q == SW'(k)) begin
                lane_px  = src_px_i[k*PX_W +: PX_W];
                lane_rdy = src_rdy_i[k];
            end
        end
    end

`ifdef GS_ROUTER_BYPASS_EN
    logic bypass_q, bypass_d;

    assign bypass_d      = start_acc ? bypass_i : bypass_q;
    assign bypass_active = bypass_q && (state_q != ST_IDLE);

    always_ff @(posedge clk_i) begin
        if (reset_i) bypass_q <= 1'b0;
        else         bypass_q <= bypass_d;
    end
`else
    assign bypass_active = 1'b0;
`endif

    // Bypass frames feed the FIFO from the source lane and ignore the core.
    assign push    = bypass_active ? accept  : core_rdy_i;
    assign push_px = bypass_active ? lane_px : core_px_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_acc) state_d = ST_RUN;
            ST_RUN:   if (abort_i) state_d = ST_IDLE; else if (last_px)  state_d = ST_DRAIN;
            ST_DRAIN: if (abort_i) state_d = ST_IDLE; else if (res_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o       = (state_q != ST_IDLE);
        frame_done_o = (state_q == ST_DRAIN) && res_done && !abort_i;
    end

    always_comb begin
        sel_d      = sel_q;
        in_cnt_d   = in_cnt_q;
        res_cnt_d  = res_cnt_q;
        overflow_d = overflow_q;
        core_rdy_d = accept && !bypass_active;
        core_px_d  = (accept && !bypass_active) ? lane_px : core_px_q;
        if (start_acc) begin
            sel_d      = (32'(src_sel_i) < NUM_SRC) ? src_sel_i : '0;
            in_cnt_d   = '0;
            res_cnt_d  = '0;
            overflow_d = 1'b0;
        end else if (abort_acc) begin
            in_cnt_d  = '0;
            res_cnt_d = '0;
        end else begin
            if (accept)              in_cnt_d  = in_cnt_q + CW'(1);
            if (push && !res_done)   res_cnt_d = res_cnt_q + CW'(1);
        end
        if (push && fifo_full && !out_pop_i && !abort_acc) overflow_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sel_q      <= '0;
            in_cnt_q   <= '0;
            res_cnt_q  <= '0;
            overflow_q <= 1'b0;
            core_rdy_q <= 1'b0;
            core_px_q  <= '0;
        end else begin
            sel_q      <= sel_d;
            in_cnt_q   <= in_cnt_d;
            res_cnt_q  <= res_cnt_d;
            overflow_q <= overflow_d;
            core_rdy_q <= core_rdy_d;
            core_px_q  <= core_px_d;
        end
    end

    gs_px_fifo #(
        .PX_W       (PX_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .flush_i   (abort_acc),
        .push_i    (push),
        .push_px_i (push_px),
        .pop_i     (out_pop_i),
        .head_px_o (out_px_o),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign core_px_o   = core_px_q;
    assign core_rdy_o  = core_rdy_q;
    assign out_valid_o = !fifo_empty;
    assign overflow_o  = overflow_q;
    assign in_cnt_o    = in_cnt_q;

endmodule

// File: tb/tb_gs_px_router.sv
// Self-checking bench for gs_px_router (NUM_SRC=3, FIFO_DEPTH=4, FRAME_LEN=4) against a queue-based frame model.
module tb_gs_px_router;

    localparam int PX_W = 8;
    localparam int NUM_SRC = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME_LEN = 4;

    logic clk = 1'b0;
    logic reset = 1'b0, start = 1'b0, abort = 1'b0, pop = 1'b0, core_rdy_in = 1'b0;
    logic [1:0] src_sel = '0;
    logic [NUM_SRC*PX_W-1:0] src_px = '0;
    logic [NUM_SRC-1:0] src_rdy = '0;
    logic [PX_W-1:0] core_px_in = '0;
    logic [PX_W-1:0] core_px_o, out_px_o;
    logic core_rdy_o, out_valid_o, busy_o, frame_done_o, overflow_o;
    logic [2:0] in_cnt_o;

    int checks = 0;
    int failures = 0;

    // Frame model: phase 0 idle / 1 feeding / 2 awaiting results.
    int m_phase, m_sel, m_in, m_res;
    logic [PX_W-1:0] m_q[$];
    bit m_ovf, m_crdy;
    logic [PX_W-1:0] m_cpx;

    gs_px_router #(
        .PX_W(PX_W), .NUM_SRC(NUM_SRC), .FIFO_DEPTH(FIFO_DEPTH), .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort), .src_sel_i(src_sel),
`ifdef GS_ROUTER_BYPASS_EN
        .bypass_i(1'b0),
`endif
        .src_px_i(src_px), .src_rdy_i(src_rdy), .core_px_o(core_px_o), .core_rdy_o(core_rdy_o),
        .core_px_i(core_px_in), .core_rdy_i(core_rdy_in), .out_px_o(out_px_o), .out_valid_o(out_valid_o),
        .out_pop_i(pop), .busy_o(busy_o), .frame_done_o(frame_done_o), .overflow_o(overflow_o),
        .in_cnt_o(in_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic model_step();
        bit start_ok, flush, acc;
        int old_res;
        logic [PX_W-1:0] lpx;
        if (reset) begin
            m_phase = 0; m_sel = 0; m_in = 0; m_res = 0; m_q.delete();
            m_ovf = 0; m_crdy = 0; m_cpx = '0;
            return;
        end
        old_res  = m_res;
        start_ok = (m_phase == 0) && start && !abort;
        flush    = (m_phase != 0) && abort;
        lpx      = src_px[m_sel*PX_W +: PX_W];
        acc      = (m_phase == 1) && !abort && src_rdy[m_sel];
        m_crdy   = acc;
        if (acc) m_cpx = lpx;
        if (start_ok) m_ovf = 0;
        if (flush) m_q.delete();
        else begin
            if (pop && m_q.size() > 0) void'(m_q.pop_front());
            if (core_rdy_in) begin
                if (m_q.size() < FIFO_DEPTH) m_q.push_back(core_px_in);
                else m_ovf = 1;
            end
        end
        if (start_ok || flush) begin
            m_in = 0; m_res = 0;
        end else begin
            if (acc) m_in++;
            if (core_rdy_in && m_res < FRAME_LEN) m_res++;
        end
        case (m_phase)
            0: if (start_ok) begin m_phase = 1; m_sel = (int'(src_sel) < NUM_SRC) ? int'(src_sel) : 0; end
            1: if (abort) m_phase = 0; else if (acc && m_in == FRAME_LEN) m_phase = 2;
            default: if (abort || old_res == FRAME_LEN) m_phase = 0;
        endcase
    endtask

    // One clock: model follows the edge, outputs settle, single-cycle pulses drop.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        start = 0; abort = 0; src_rdy = '0; core_rdy_in = 0; pop = 0;
    endtask

    task automatic do_reset();
        reset = 1; tick(); reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; tick(); tick();
        checks++; if (core_px_o !== 8'h00) begin failures++; $display("FAIL reset_core_px got=%h exp=00", core_px_o); end
        checks++; if (core_rdy_o !== 1'b0) begin failures++; $display("FAIL reset_core_rdy got=%b exp=0", core_rdy_o); end
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); end
        checks++; if (out_px_o !== 8'h00) begin failures++; $display("FAIL reset_out_px got=%h exp=00", out_px_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (frame_done_o !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done_o); end
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow_o); end
        checks++; if (in_cnt_o !== 3'd0) begin failures++; $display("FAIL reset_in_cnt got=%0d exp=0", in_cnt_o); end
        reset = 0;
    endtask

    task automatic test_frame();
        logic [PX_W-1:0] pix [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int sent = 0, seen = 0, guard = 0;
        bit fired;
        do_reset();
        src_sel = 2; start = 1; tick();
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL frame_busy got=%b exp=1", busy_o); end
        while (sent < 4 && guard < 200) begin
            guard++;
            src_rdy[1:0] = 2'($urandom);
            src_px[15:0] = 16'($urandom);
            fired = ($urandom_range(0, 1) == 1);
            if (fired) begin src_rdy[2] = 1; src_px[23:16] = pix[sent]; end
            tick();
            checks++; if (core_rdy_o !== fired) begin failures++; $display("FAIL frame_core_rdy got=%b exp=%b", core_rdy_o, fired); end
            if (fired) begin
                checks++; if (core_px_o !== pix[sent]) begin failures++; $display("FAIL frame_core_px got=%h exp=%h", core_px_o, pix[sent]); end
                sent++;
            end
            if (core_rdy_o) seen++;
        end
        checks++; if (sent != 4) begin failures++; $display("FAIL frame_feed_budget got=%0d exp=4", sent); end
        for (int i = 0; i < 3; i++) begin
            src_rdy = 3'b111; src_px = 24'($urandom);
            tick();
            if (core_rdy_o) seen++;
        end
        checks++; if (seen != 4) begin failures++; $display("FAIL frame_pulse_count got=%0d exp=4", seen); end
        checks++; if (in_cnt_o !== 3'd4) begin failures++; $display("FAIL frame_in_cnt got=%0d exp=4", in_cnt_o); end
        checks++; if (busy_o !== 1'b1 || frame_done_o !== 1'b0) begin failures++; $display("FAIL frame_drain got=%b%b exp=10", busy_o, frame_done_o); end
        for (int i = 0; i < 4; i++) begin
            core_px_in = 8'hA0 + 8'(i); core_rdy_in = 1; tick();
            checks++; if (out_valid_o !== 1'b1 || out_px_o !== 8'hA0 + 8'(i)) begin failures++; $display("FAIL result_head got=%b/%h exp=1/%h", out_valid_o, out_px_o, 8'hA0 + 8'(i)); end
            checks++; if (frame_done_o !== (i == 3)) begin failures++; $display("FAIL result_done got=%b exp=%b", frame_done_o, (i == 3)); end
            pop = 1; tick();
            checks++; if (out_valid_o !== 1'b0 || frame_done_o !== 1'b0) begin failures++; $display("FAIL result_after_pop got=%b%b exp=00", out_valid_o, frame_done_o); end
            checks++; if (busy_o !== (i != 3)) begin failures++; $display("FAIL result_busy got=%b exp=%b", busy_o, (i != 3)); end
        end
    endtask

    task automatic test_overflow();
        logic [PX_W-1:0] d [6];
        do_reset();
        for (int i = 0; i < 6; i++) begin
            d[i] = 8'($urandom); core_px_in = d[i]; core_rdy_in = 1; tick();
        end
        checks++; if (out_valid_o !== 1'b1) begin failures++; $display("FAIL ovf_valid got=%b exp=1", out_valid_o); end
        checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow_o); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid_o !== 1'b1 || out_px_o !== d[i]) begin failures++; $display("FAIL ovf_pop%0d got=%b/%h exp=1/%h", i, out_valid_o, out_px_o, d[i]); end
            pop = 1; tick();
        end
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%b exp=0", out_valid_o); end
        checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow_o); end
    endtask

    task automatic test_full_push_pop();
        logic [PX_W-1:0] d [5];
        do_reset();
        for (int i = 0; i < 5; i++) d[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) begin core_px_in = d[i]; core_rdy_in = 1; tick(); end
        core_px_in = d[4]; core_rdy_in = 1; pop = 1; tick();
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL full_pp_overflow got=%b exp=0", overflow_o); end
        for (int i = 1; i < 5; i++) begin
            checks++; if (out_valid_o !== 1'b1 || out_px_o !== d[i]) begin failures++; $display("FAIL full_pp_head%0d got=%b/%h exp=1/%h", i, out_valid_o, out_px_o, d[i]); end
            pop = 1; tick();
        end
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL full_pp_count got=%b exp=0", out_valid_o); end
    endtask

    task automatic test_abort();
        logic [PX_W-1:0] p0;
        int lane;
        do_reset();
        lane = $urandom_range(0, NUM_SRC - 1);
        src_sel = 2'(lane); start = 1; tick();
        for (int i = 0; i < 2; i++) begin
            src_rdy[lane] = 1; src_px = 24'($urandom); core_px_in = 8'($urandom); core_rdy_in = 1; tick();
        end
        checks++; if (in_cnt_o !== 3'd2 || out_valid_o !== 1'b1) begin failures++; $display("FAIL abort_pre got=%0d/%b exp=2/1", in_cnt_o, out_valid_o); end
        abort = 1; tick();
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy_o); end
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL abort_fifo got=%b exp=0", out_valid_o); end
        checks++; if (in_cnt_o !== 3'd0) begin failures++; $display("FAIL abort_in_cnt got=%0d exp=0", in_cnt_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (frame_done_o !== 1'b0 || core_rdy_o !== 1'b0) begin failures++; $display("FAIL abort_quiet got=%b%b exp=00", frame_done_o, core_rdy_o); end
        end
        src_sel = 2'd3; start = 1; tick();
        p0 = 8'($urandom);
        src_rdy = 3'b001; src_px = {16'($urandom), p0}; tick();
        checks++; if (core_rdy_o !== 1'b1 || core_px_o !== p0) begin failures++; $display("FAIL abort_badsel got=%b/%h exp=1/%h", core_rdy_o, core_px_o, p0); end
        src_rdy = 3'b110; src_px = 24'($urandom); tick();
        checks++; if (core_rdy_o !== 1'b0) begin failures++; $display("FAIL abort_badsel_other got=%b exp=0", core_rdy_o); end
    endtask

    task automatic test_reset_drain();
        do_reset();
        src_sel = 1; start = 1; tick();
        for (int i = 0; i < 4; i++) begin src_rdy = 3'b010; src_px = 24'($urandom); tick(); end
        for (int i = 0; i < 3; i++) begin core_px_in = 8'($urandom); core_rdy_in = 1; tick(); end
        checks++; if (busy_o !== 1'b1 || out_valid_o !== 1'b1) begin failures++; $display("FAIL rd_pre got=%b%b exp=11", busy_o, out_valid_o); end
        reset = 1; tick();
        checks++; if ({core_px_o, core_rdy_o, out_valid_o, out_px_o, busy_o, frame_done_o, overflow_o, in_cnt_o} !== '0) begin
            failures++; $display("FAIL rd_outputs got=%h/%b/%b/%h/%b/%b/%b/%0d exp=all0", core_px_o, core_rdy_o, out_valid_o, out_px_o, busy_o, frame_done_o, overflow_o, in_cnt_o);
        end
        reset = 0; src_sel = 0; start = 1; tick();
        checks++; if (busy_o !== 1'b1 || in_cnt_o !== 3'd0) begin failures++; $display("FAIL rd_restart got=%b/%0d exp=1/0", busy_o, in_cnt_o); end
    endtask

    task automatic test_random();
        logic [PX_W-1:0] exp_head;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            start       = ($urandom_range(0, 7) == 0);
            abort       = ($urandom_range(0, 40) == 0);
            src_sel     = 2'($urandom);
            src_px      = 24'($urandom);
            src_rdy     = 3'($urandom);
            core_px_in  = 8'($urandom);
            core_rdy_in = ($urandom_range(0, 1) == 1);
            pop         = ($urandom_range(0, 2) == 0);
            tick();
            exp_head = (m_q.size() > 0) ? m_q[0] : 8'h00;
            checks++; if (core_rdy_o !== m_crdy) begin failures++; $display("FAIL rnd_core_rdy c=%0d got=%b exp=%b", c, core_rdy_o, m_crdy); end
            checks++; if (core_px_o !== m_cpx) begin failures++; $display("FAIL rnd_core_px c=%0d got=%h exp=%h", c, core_px_o, m_cpx); end
            checks++; if (out_valid_o !== (m_q.size() > 0) || out_px_o !== exp_head) begin failures++; $display("FAIL rnd_head c=%0d got=%b/%h exp=%b/%h", c, out_valid_o, out_px_o, (m_q.size() > 0), exp_head); end
            checks++; if (busy_o !== (m_phase != 0)) begin failures++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy_o, (m_phase != 0)); end
            checks++; if (frame_done_o !== (m_phase == 2 && m_res == FRAME_LEN)) begin failures++; $display("FAIL rnd_done c=%0d got=%b exp=%b", c, frame_done_o, (m_phase == 2 && m_res == FRAME_LEN)); end
            checks++; if (overflow_o !== m_ovf) begin failures++; $display("FAIL rnd_overflow c=%0d got=%b exp=%b", c, overflow_o, m_ovf); end
            checks++; if (int'(in_cnt_o) != m_in) begin failures++; $display("FAIL rnd_in_cnt c=%0d got=%0d exp=%0d", c, in_cnt_o, m_in); end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_overflow();
        test_full_push_pop();
        test_abort();
        test_reset_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
